// File: rtl/basic_control_unit_if.sv
// Control/status bundle between the basic-computer sequencer and its datapath.
// The sequencer (master) reads IR and the datapath flags and drives every strobe.
interface basic_control_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] ir;
  logic             ac_sign;
  logic             ac_zero;
  logic             e_flag;
  logic             dr_zero;

  logic [2:0]       bus_sel;
  logic [2:0]       op_select;
  logic             ar_ld;
  logic             ar_inc;
  logic             pc_ld;
  logic             pc_inc;
  logic             dr_ld;
  logic             dr_inc;
  logic             ac_ld;
  logic             ac_clr;
  logic             ac_inc;
  logic             ir_ld;
  logic             tr_ld;
  logic             e_ld;
  logic             e_clr;
  logic             e_cmp;
  logic             mem_wr;
  logic [2:0]       seq;
  logic             halted;

  modport master (
    input  ir, ac_sign, ac_zero, e_flag, dr_zero,
    output bus_sel, op_select, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc,
           ac_ld, ac_clr, ac_inc, ir_ld, tr_ld, e_ld, e_clr, e_cmp, mem_wr,
           seq, halted
  );

  modport slave (
    output ir, ac_sign, ac_zero, e_flag, dr_zero,
    input  bus_sel, op_select, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc,
           ac_ld, ac_clr, ac_inc, ir_ld, tr_ld, e_ld, e_clr, e_cmp, mem_wr,
           seq, halted
  );
endinterface

// File: rtl/basic_control_unit.sv
// Timing-and-control sequencer for the 16-bit basic computer: runs T0..T6 through
// fetch, decode, indirect and execute, decoding strobes combinationally from SC.
module basic_control_unit (
  input  logic                  clk,
  input  logic                  rst,
  basic_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } sc_e;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_LDA = 3'b011;
  localparam logic [2:0] OP_CMA = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  localparam logic [2:0] D_AND = 3'd0;
  localparam logic [2:0] D_ADD = 3'd1;
  localparam logic [2:0] D_LDA = 3'd2;
  localparam logic [2:0] D_STA = 3'd3;
  localparam logic [2:0] D_BUN = 3'd4;
  localparam logic [2:0] D_BSA = 3'd5;
  localparam logic [2:0] D_ISZ = 3'd6;
  localparam logic [2:0] D_REG = 3'd7;

  sc_e        sc_q, sc_d;
  logic       i_lat_q, i_lat_d;
  logic [2:0] d_lat_q, d_lat_d;
  logic       halted_q, halted_d;

  logic [2:0] bus_sel_c, op_select_c;
  logic ar_ld_c, ar_inc_c, pc_ld_c, pc_inc_c, dr_ld_c, dr_inc_c, ac_ld_c;
  logic ac_clr_c, ac_inc_c, ir_ld_c, e_ld_c, e_clr_c, e_cmp_c, mem_wr_c;

  // Next-state and control decode; everything idles at T0 once halted.
  always_comb begin
    sc_d        = sc_q;
    i_lat_d     = i_lat_q;
    d_lat_d     = d_lat_q;
    halted_d    = halted_q;
    bus_sel_c   = BUS_NONE;
    op_select_c = 3'b000;
    ar_ld_c  = 1'b0; ar_inc_c = 1'b0; pc_ld_c  = 1'b0; pc_inc_c = 1'b0;
    dr_ld_c  = 1'b0; dr_inc_c = 1'b0; ac_ld_c  = 1'b0; ac_clr_c = 1'b0;
    ac_inc_c = 1'b0; ir_ld_c  = 1'b0; e_ld_c   = 1'b0; e_clr_c  = 1'b0;
    e_cmp_c  = 1'b0; mem_wr_c = 1'b0;

    if (halted_q) begin
      sc_d = T0;
    end else begin
      case (sc_q)
        T0: begin
          bus_sel_c = BUS_PC; ar_ld_c = 1'b1; sc_d = T1;
        end
        T1: begin
          bus_sel_c = BUS_MEM; ir_ld_c = 1'b1; pc_inc_c = 1'b1; sc_d = T2;
        end
        T2: begin
          bus_sel_c = BUS_IR; ar_ld_c = 1'b1;
          i_lat_d   = bus.ir[15];
          d_lat_d   = bus.ir[14:12];
          sc_d      = T3;
        end
        T3: begin
          if (d_lat_q == D_REG) begin
            sc_d = T0;
            // Register reference: only the highest set bit of IR[11:0] executes.
            if (!i_lat_q) begin
              if      (bus.ir[11]) ac_clr_c = 1'b1;
              else if (bus.ir[10]) e_clr_c  = 1'b1;
              else if (bus.ir[9])  begin op_select_c = OP_CMA; ac_ld_c = 1'b1; end
              else if (bus.ir[8])  e_cmp_c  = 1'b1;
              else if (bus.ir[7])  begin op_select_c = OP_SHR; ac_ld_c = 1'b1; e_ld_c = 1'b1; end
              else if (bus.ir[6])  begin op_select_c = OP_SHL; ac_ld_c = 1'b1; e_ld_c = 1'b1; end
              else if (bus.ir[5])  ac_inc_c = 1'b1;
              else if (bus.ir[4])  pc_inc_c = !bus.ac_sign;
              else if (bus.ir[3])  pc_inc_c = bus.ac_sign;
              else if (bus.ir[2])  pc_inc_c = bus.ac_zero;
              else if (bus.ir[1])  pc_inc_c = !bus.e_flag;
              else if (bus.ir[0])  halted_d = 1'b1;
            end
          end else begin
            if (i_lat_q) begin
              bus_sel_c = BUS_MEM; ar_ld_c = 1'b1;
            end
            sc_d = T4;
          end
        end
        T4: begin
          sc_d = T5;
          case (d_lat_q)
            D_AND, D_ADD, D_LDA, D_ISZ: begin bus_sel_c = BUS_MEM; dr_ld_c = 1'b1; end
            D_STA: begin bus_sel_c = BUS_AC; mem_wr_c = 1'b1; sc_d = T0; end
            D_BUN: begin bus_sel_c = BUS_AR; pc_ld_c  = 1'b1; sc_d = T0; end
            D_BSA: begin bus_sel_c = BUS_PC; mem_wr_c = 1'b1; ar_inc_c = 1'b1; end
            default: sc_d = T0;
          endcase
        end
        T5: begin
          sc_d = T0;
          case (d_lat_q)
            D_AND: begin op_select_c = OP_AND; ac_ld_c = 1'b1; end
            D_ADD: begin op_select_c = OP_ADD; ac_ld_c = 1'b1; e_ld_c = 1'b1; end
            D_LDA: begin op_select_c = OP_LDA; ac_ld_c = 1'b1; end
            D_BSA: begin bus_sel_c = BUS_AR; pc_ld_c = 1'b1; end
            D_ISZ: begin dr_inc_c = 1'b1; sc_d = T6; end
            default: ;
          endcase
        end
        T6: begin
          sc_d = T0;
          // Only ISZ legitimately reaches T6; anything else just returns to fetch.
          if (d_lat_q == D_ISZ) begin
            bus_sel_c = BUS_DR; mem_wr_c = 1'b1; pc_inc_c = bus.dr_zero;
          end
        end
        default: sc_d = T0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q     <= T0;
      i_lat_q  <= 1'b0;
      d_lat_q  <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      i_lat_q  <= i_lat_d;
      d_lat_q  <= d_lat_d;
      halted_q <= halted_d;
    end
  end

  // Reset masks every output, including status.
  assign bus.bus_sel   = rst ? 3'd0 : bus_sel_c;
  assign bus.op_select = rst ? 3'd0 : op_select_c;
  assign bus.ar_ld     = !rst && ar_ld_c;
  assign bus.ar_inc    = !rst && ar_inc_c;
  assign bus.pc_ld     = !rst && pc_ld_c;
  assign bus.pc_inc    = !rst && pc_inc_c;
  assign bus.dr_ld     = !rst && dr_ld_c;
  assign bus.dr_inc    = !rst && dr_inc_c;
  assign bus.ac_ld     = !rst && ac_ld_c;
  assign bus.ac_clr    = !rst && ac_clr_c;
  assign bus.ac_inc    = !rst && ac_inc_c;
  assign bus.ir_ld     = !rst && ir_ld_c;
  assign bus.tr_ld     = 1'b0;
  assign bus.e_ld      = !rst && e_ld_c;
  assign bus.e_clr     = !rst && e_clr_c;
  assign bus.e_cmp     = !rst && e_cmp_c;
  assign bus.mem_wr    = !rst && mem_wr_c;
  assign bus.seq       = rst ? 3'd0 : sc_q;
  assign bus.halted    = !rst && halted_q;

endmodule
